// File: rtl/hwpe_ctrl_periph_initiator_pkg.sv
// -----------------------------------------------------------------------------
// hwpe_ctrl_package
// Shared types for the HWPE peripheral initiator and its reorder buffer.
//   periph_cmd_t           : one bus request (address, read/write, byte enables,
//                            write data) as held in the request register.
//   periph_rsp_t           : one completed response slot (data, echoed wen,
//                            timeout flag).
//   HWPE_CTRL_TIMEOUT_DATA : data returned for a transaction that timed out.
// -----------------------------------------------------------------------------
package hwpe_ctrl_package;

   localparam logic [31:0] HWPE_CTRL_TIMEOUT_DATA = 32'hDEADBEEF;

   typedef struct packed {
      logic [31:0] add;
      logic        wen;   // 1 = read, 0 = write (bus polarity)
      logic [3:0]  be;
      logic [31:0] data;
   } periph_cmd_t;

   typedef struct packed {
      logic [31:0] data;
      logic        wen;
      logic        err;
   } periph_rsp_t;

endpackage

// File: rtl/hwpe_ctrl_periph_initiator_if.sv
// -----------------------------------------------------------------------------
// hwpe_ctrl_periph_initiator_if
// HWPE peripheral control bus (request/grant plus tagged response channel).
//   master modport : drives req/add/wen/be/data/id, receives gnt and r_*.
//   slave modport  : the mirror image, for a target or a bench.
// Parameter ID_WIDTH sets the width of id and r_id.
// -----------------------------------------------------------------------------
interface hwpe_ctrl_periph_initiator_if #(
   parameter int unsigned ID_WIDTH = 2
);
   logic                req;
   logic                gnt;
   logic [31:0]         add;
   logic                wen;
   logic [3:0]          be;
   logic [31:0]         data;
   logic [ID_WIDTH-1:0] id;
   logic [31:0]         r_data;
   logic                r_valid;
   logic [ID_WIDTH-1:0] r_id;

   modport master (
      output req, add, wen, be, data, id,
      input  gnt, r_data, r_valid, r_id
   );

   modport slave (
      input  req, add, wen, be, data, id,
      output gnt, r_data, r_valid, r_id
   );

endinterface

// File: rtl/hwpe_ctrl_periph_initiator_rob.sv
// -----------------------------------------------------------------------------
// hwpe_ctrl_periph_rob
// Response slot table for the peripheral initiator. Slots are allocated in a
// ring (alloc pointer), completed out of order by tagged responses and retired
// in allocation order (retire pointer).
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   alloc_i            : allocate the slot at alloc_ptr_o (command accepted)
//   alloc_wen_i        : wen of the allocated command
//   alloc_ok_o         : slot at alloc_ptr_o is free, or frees this cycle
//   alloc_ptr_o        : slot index used as the bus transaction id
//   rvalid_i/rid_i/rdata_i : bus response channel
//   force_done_i       : complete the head slot with the timeout pattern
//   retire_i           : head slot is handed out this cycle
//   head_done_o        : head slot holds a completed response
//   head_rsp_o         : head slot contents
//   outstanding_o      : allocated, not yet retired slots
//   id_err_o           : sticky unexpected-response flag
// -----------------------------------------------------------------------------
module hwpe_ctrl_periph_rob
   import hwpe_ctrl_package::*;
#(
   parameter int unsigned ID_WIDTH        = 2,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 alloc_i,
   input  logic                                 alloc_wen_i,
   output logic                                 alloc_ok_o,
   output logic [$clog2(MAX_OUTSTANDING)-1:0]   alloc_ptr_o,
   input  logic                                 rvalid_i,
   input  logic [ID_WIDTH-1:0]                  rid_i,
   input  logic [31:0]                          rdata_i,
   input  logic                                 force_done_i,
   input  logic                                 retire_i,
   output logic                                 head_done_o,
   output periph_rsp_t                          head_rsp_o,
   output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
   output logic                                 id_err_o
);

   localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CW = PW + 1;

   logic [MAX_OUTSTANDING-1:0] busy_q, busy_d;
   logic [MAX_OUTSTANDING-1:0] done_q, done_d;
   periph_rsp_t [MAX_OUTSTANDING-1:0] slot_q, slot_d;
   logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
   logic [PW-1:0] retire_ptr_q, retire_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          id_err_q, id_err_d;

   logic [PW-1:0] rid_idx;
   logic          rid_in_range;

   assign rid_idx      = rid_i[PW-1:0];
   assign rid_in_range = (32'(rid_i) < MAX_OUTSTANDING);

   // When the table is full the allocation target is the head; retiring it
   // in the same cycle lets a new command in without a bubble.
   assign alloc_ok_o    = !busy_q[alloc_ptr_q] ||
                          (retire_i && (retire_ptr_q == alloc_ptr_q));
   assign alloc_ptr_o   = alloc_ptr_q;
   assign head_done_o   = done_q[retire_ptr_q];
   assign head_rsp_o    = slot_q[retire_ptr_q];
   assign outstanding_o = cnt_q;
   assign id_err_o      = id_err_q;

   always_comb begin
      busy_d       = busy_q;
      done_d       = done_q;
      slot_d       = slot_q;
      id_err_d     = id_err_q;
      alloc_ptr_d  = alloc_ptr_q;
      retire_ptr_d = retire_ptr_q;

      if (rvalid_i) begin
         if (rid_in_range && busy_q[rid_idx] && !done_q[rid_idx]) begin
            done_d[rid_idx]      = 1'b1;
            slot_d[rid_idx].data = slot_q[rid_idx].wen ? rdata_i : 32'h0;
         end else if (!(rid_in_range && busy_q[rid_idx] && slot_q[rid_idx].err)) begin
            // A late answer to a timed-out slot that is still held is dropped
            // quietly; anything else has no owner.
            id_err_d = 1'b1;
         end
      end

      // A real response to the head in the same cycle takes precedence.
      if (force_done_i && busy_q[retire_ptr_q] && !done_d[retire_ptr_q]) begin
         done_d[retire_ptr_q]      = 1'b1;
         slot_d[retire_ptr_q].data = HWPE_CTRL_TIMEOUT_DATA;
         slot_d[retire_ptr_q].err  = 1'b1;
      end

      if (retire_i) begin
         busy_d[retire_ptr_q] = 1'b0;
         done_d[retire_ptr_q] = 1'b0;
         retire_ptr_d         = retire_ptr_q + PW'(1);
      end

      // Allocation last: it wins over a retire of the same slot.
      if (alloc_i) begin
         busy_d[alloc_ptr_q] = 1'b1;
         done_d[alloc_ptr_q] = 1'b0;
         slot_d[alloc_ptr_q] = '{data: 32'h0, wen: alloc_wen_i, err: 1'b0};
         alloc_ptr_d         = alloc_ptr_q + PW'(1);
      end

      cnt_d = cnt_q + CW'(alloc_i) - CW'(retire_i);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q       <= '0;
         done_q       <= '0;
         slot_q       <= '0;
         alloc_ptr_q  <= '0;
         retire_ptr_q <= '0;
         cnt_q        <= '0;
         id_err_q     <= 1'b0;
      end else begin
         busy_q       <= busy_d;
         done_q       <= done_d;
         slot_q       <= slot_d;
         alloc_ptr_q  <= alloc_ptr_d;
         retire_ptr_q <= retire_ptr_d;
         cnt_q        <= cnt_d;
         id_err_q     <= id_err_d;
      end
   end

endmodule

// File: rtl/hwpe_ctrl_periph_initiator.sv
// -----------------------------------------------------------------------------
// hwpe_ctrl_periph_initiator
// Initiator end of the HWPE peripheral control protocol. Turns a valid/ready
// command stream into tagged bus transactions and returns the responses in
// issue order on a valid/ready response stream.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   cmd_*             : command stream (add, wen 1=read, be, data)
//   periph            : bus master modport (req/gnt/add/wen/be/data/id, r_*)
//   rsp_*             : response stream (data, echoed wen, timeout err)
//   outstanding_o     : slots allocated and not yet retired
//   id_err_o          : sticky flag for responses with no owning slot
// Optional feature macro: HWPE_CTRL_PERIPH_INITIATOR_TIMEOUT_EN
//   Defined  : a head-of-line counter completes a stuck head slot after
//              TIMEOUT_CYCLES with data 32'hDEADBEEF and rsp_err_o=1.
//   Undefined: the head waits indefinitely and rsp_err_o stays 0.
// -----------------------------------------------------------------------------
module hwpe_ctrl_periph_initiator
   import hwpe_ctrl_package::*;
#(
   parameter int unsigned ID_WIDTH        = 2,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 256
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              cmd_valid_i,
   output logic                              cmd_ready_o,
   input  logic [31:0]                       cmd_add_i,
   input  logic                              cmd_wen_i,
   input  logic [3:0]                        cmd_be_i,
   input  logic [31:0]                       cmd_data_i,
   hwpe_ctrl_periph_initiator_if.master      periph,
   output logic                              rsp_valid_o,
   input  logic                              rsp_ready_i,
   output logic [31:0]                       rsp_data_o,
   output logic                              rsp_wen_o,
   output logic                              rsp_err_o,
   output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
   output logic                              id_err_o
);

   localparam int unsigned PW = $clog2(MAX_OUTSTANDING);

   if ((MAX_OUTSTANDING < 2) || ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0)) begin : g_chk_slots
      $error("MAX_OUTSTANDING must be a power of two and at least 2");
   end
   if ((1 << ID_WIDTH) < MAX_OUTSTANDING) begin : g_chk_id
      $error("ID_WIDTH too narrow to tag MAX_OUTSTANDING slots");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   logic                req_q, req_d;
   periph_cmd_t         cmd_q, cmd_d;
   logic [ID_WIDTH-1:0] id_q, id_d;

   logic          accept;
   logic          retire;
   logic          alloc_ok;
   logic [PW-1:0] alloc_ptr;
   logic          head_done;
   periph_rsp_t   head_rsp;
   logic          force_done;

   // The request register may reload in the cycle its current request is
   // granted, giving one transaction per cycle.
   assign cmd_ready_o = (!req_q || periph.gnt) && alloc_ok;
   assign accept      = cmd_valid_i && cmd_ready_o;
   assign retire      = head_done && rsp_ready_i;

   always_comb begin
      req_d = req_q;
      cmd_d = cmd_q;
      id_d  = id_q;
      if (accept) begin
         req_d = 1'b1;
         cmd_d = '{add: cmd_add_i, wen: cmd_wen_i, be: cmd_be_i, data: cmd_data_i};
         id_d  = ID_WIDTH'(alloc_ptr);
      end else if (periph.gnt) begin
         req_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_q <= 1'b0;
         cmd_q <= '0;
         id_q  <= '0;
      end else begin
         req_q <= req_d;
         cmd_q <= cmd_d;
         id_q  <= id_d;
      end
   end

   assign periph.req  = req_q;
   assign periph.add  = cmd_q.add;
   assign periph.wen  = cmd_q.wen;
   assign periph.be   = cmd_q.be;
   assign periph.data = cmd_q.data;
   assign periph.id   = id_q;

   hwpe_ctrl_periph_rob #(
      .ID_WIDTH        (ID_WIDTH),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) i_rob (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .alloc_i       (accept),
      .alloc_wen_i   (cmd_wen_i),
      .alloc_ok_o    (alloc_ok),
      .alloc_ptr_o   (alloc_ptr),
      .rvalid_i      (periph.r_valid),
      .rid_i         (periph.r_id),
      .rdata_i       (periph.r_data),
      .force_done_i  (force_done),
      .retire_i      (retire),
      .head_done_o   (head_done),
      .head_rsp_o    (head_rsp),
      .outstanding_o (outstanding_o),
      .id_err_o      (id_err_o)
   );

`ifdef HWPE_CTRL_PERIPH_INITIATOR_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          head_pending;

   // Slots are used as a ring, so the head is allocated whenever anything is.
   assign head_pending = (outstanding_o != '0) && !head_done;

   always_comb begin
      to_cnt_d   = to_cnt_q;
      force_done = 1'b0;
      if (retire) begin
         to_cnt_d = '0;
      end else if (head_pending) begin
         if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            force_done = 1'b1;
            to_cnt_d   = '0;
         end else begin
            to_cnt_d = to_cnt_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) to_cnt_q <= '0;
      else       to_cnt_q <= to_cnt_d;
   end
`else
   assign force_done = 1'b0;
`endif

   assign rsp_valid_o = head_done;
   assign rsp_data_o  = head_rsp.data;
   assign rsp_wen_o   = head_rsp.wen;
   // Slot err flags are only ever set by the timeout, so without it this
   // output is constant 0.
   assign rsp_err_o   = head_rsp.err;

endmodule

// File: tb/tb_hwpe_ctrl_periph_initiator.sv
module tb_hwpe_ctrl_periph_initiator;
   import hwpe_ctrl_package::*;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int TO  = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_add  = '0;
   logic        cmd_wen  = 1'b0;
   logic [3:0]  cmd_be   = '0;
   logic [31:0] cmd_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_wen;
   logic        rsp_err;
   logic [2:0]  outstanding;
   logic        id_err;

   hwpe_ctrl_periph_initiator_if #(.ID_WIDTH(IDW)) periph ();

   hwpe_ctrl_periph_initiator #(
      .ID_WIDTH(IDW), .MAX_OUTSTANDING(N), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_add_i(cmd_add),
      .cmd_wen_i(cmd_wen), .cmd_be_i(cmd_be), .cmd_data_i(cmd_data),
      .periph(periph),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
      .rsp_wen_o(rsp_wen), .rsp_err_o(rsp_err),
      .outstanding_o(outstanding), .id_err_o(id_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: in-order list of live transactions
   typedef struct {
      int          id;
      bit          wen;
      bit          done;
      bit          timed;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   bit          m_req;
   int          m_id;
   logic [31:0] m_add, m_data;
   bit          m_wen;
   logic [3:0]  m_be;
   int          m_next;
   bit          m_err;
   int          m_age;

   function automatic void m_reset();
      mq.delete();
      m_req = 0; m_id = 0; m_add = '0; m_data = '0; m_wen = 0; m_be = '0;
      m_next = 0; m_err = 0; m_age = 0;
   endfunction

   // values seen by the last cyc() call
   logic        s_ready, s_req, s_rsp_valid, s_rsp_err, s_id_err;
   int          s_id, s_out;
   logic [31:0] s_rsp_data;
   logic [31:0] rsp_log[$];

   // Called just after a falling edge with inputs already applied: checks the
   // DUT against the model, advances the model across the next rising edge.
   task automatic cyc();
      bit e_rv, e_ready, hit, silent;
      #1;
      e_rv    = (mq.size() > 0) && mq[0].done;
      e_ready = (!m_req || periph.gnt) && ((mq.size() < N) || (e_rv && rsp_ready));
      s_ready = cmd_ready; s_req = periph.req; s_id = int'(periph.id);
      s_rsp_valid = rsp_valid; s_rsp_data = rsp_data; s_rsp_err = rsp_err;
      s_id_err = id_err; s_out = int'(outstanding);

      chk("cmd_ready", cmd_ready, e_ready);
      chk("req", periph.req, m_req);
      if (m_req) begin
         chk("req_id", periph.id, m_id);
         chk("req_add", periph.add, m_add);
         chk("req_wen", periph.wen, m_wen);
         chk("req_be", periph.be, m_be);
         chk("req_data", periph.data, m_data);
      end
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv) begin
         chk("rsp_data", rsp_data, mq[0].data);
         chk("rsp_wen", rsp_wen, mq[0].wen);
         chk("rsp_err", rsp_err, mq[0].timed);
      end
      chk("outstanding", outstanding, mq.size());
      chk("id_err", id_err, m_err);
      if (rsp_valid && rsp_ready) rsp_log.push_back(rsp_data);

      if (periph.r_valid) begin
         hit = 0; silent = 0;
         foreach (mq[i]) begin
            if (!hit && mq[i].id == int'(periph.r_id) && !mq[i].done) begin
               mq[i].done = 1;
               mq[i].data = mq[i].wen ? periph.r_data : 32'h0;
               hit = 1;
            end
         end
         if (!hit) begin
            foreach (mq[i]) if (mq[i].id == int'(periph.r_id) && mq[i].timed) silent = 1;
            if (!silent) m_err = 1;
         end
      end
`ifdef HWPE_CTRL_PERIPH_INITIATOR_TIMEOUT_EN
      if (mq.size() > 0 && !mq[0].done) begin
         if (m_age == TO - 1) begin
            mq[0].done = 1; mq[0].timed = 1; mq[0].data = HWPE_CTRL_TIMEOUT_DATA;
            m_age = 0;
         end else begin
            m_age++;
         end
      end
`endif
      if (e_rv && rsp_ready) begin
         void'(mq.pop_front());
         m_age = 0;
      end
      if (cmd_valid && e_ready) begin
         mq.push_back('{id: m_next, wen: cmd_wen, done: 0, timed: 0, data: 32'h0});
         m_req = 1; m_id = m_next; m_add = cmd_add; m_wen = cmd_wen;
         m_be = cmd_be; m_data = cmd_data;
         m_next = (m_next + 1) % N;
      end else if (periph.gnt) begin
         m_req = 0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cmd_valid = 0; rsp_ready = 0;
      periph.gnt = 0; periph.r_valid = 0; periph.r_id = '0; periph.r_data = '0;
      #1;
      chk("rst_req", periph.req, 1'b0);
      chk("rst_add", periph.add, 32'h0);
      chk("rst_id", periph.id, 2'd0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk("rst_outstanding", outstanding, 3'd0);
      chk("rst_id_err", id_err, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_reset();
      rsp_log.delete();
   endtask

   // ---------------- directed single write, table driven
   typedef struct {
      logic        cv;
      logic [31:0] add, data;
      logic        wen, gnt, rv;
      logic [1:0]  rid;
      logic [31:0] rdata;
      logic        rr;
      logic        e_ready, e_req;
      int          e_id;
      logic        e_rv;
      logic [31:0] e_rdata;
      int          e_out;
   } vec_t;

   vec_t tbl[6];
   int   granted[$];

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      periph.gnt = 0; periph.r_valid = 0; periph.r_id = '0; periph.r_data = '0;
      @(negedge clk);
      do_reset();

      //          cv add    data wen gnt rv rid rdata   rr  rdy req id rv rdata out
      tbl[0] = '{1, 32'h20, 5,   0,  0,  0, 0,  0,      0,  1,  0,  0, 0, 0,    0};
      tbl[1] = '{0, 32'h0,  0,   0,  0,  0, 0,  0,      0,  0,  1,  0, 0, 0,    1};
      tbl[2] = '{0, 32'h0,  0,   0,  1,  0, 0,  0,      0,  1,  1,  0, 0, 0,    1};
      tbl[3] = '{0, 32'h0,  0,   0,  0,  1, 0,  32'h1234, 0, 1, 0,  0, 0, 0,    1};
      tbl[4] = '{0, 32'h0,  0,   0,  0,  0, 0,  0,      1,  1,  0,  0, 1, 0,    1};
      tbl[5] = '{0, 32'h0,  0,   0,  0,  0, 0,  0,      1,  1,  0,  0, 0, 0,    0};
      for (int i = 0; i < 6; i++) begin
         cmd_valid = tbl[i].cv; cmd_add = tbl[i].add; cmd_data = tbl[i].data;
         cmd_wen = tbl[i].wen; cmd_be = 4'hF;
         periph.gnt = tbl[i].gnt; periph.r_valid = tbl[i].rv;
         periph.r_id = tbl[i].rid; periph.r_data = tbl[i].rdata;
         rsp_ready = tbl[i].rr;
         cyc();
         chk($sformatf("wr%0d_ready", i), s_ready, tbl[i].e_ready);
         chk($sformatf("wr%0d_req", i), s_req, tbl[i].e_req);
         if (tbl[i].e_req) chk($sformatf("wr%0d_id", i), s_id, tbl[i].e_id);
         chk($sformatf("wr%0d_rsp_valid", i), s_rsp_valid, tbl[i].e_rv);
         if (tbl[i].e_rv) chk($sformatf("wr%0d_rsp_data", i), s_rsp_data, tbl[i].e_rdata);
         chk($sformatf("wr%0d_out", i), s_out, tbl[i].e_out);
      end
      rsp_ready = 0;

      // ---------------- streaming reads, full table, out-of-order responses
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1; cmd_wen = 1; cmd_add = 32'h100 + 32'(4 * i);
         cmd_be = 4'hF; cmd_data = 0; periph.gnt = 1;
         cyc();
         if (i >= 1) begin
            chk("stream_req", s_req, 1'b1);
            chk("stream_id", s_id, i - 1);
         end
         if (i == 4) chk("stream_full_ready", s_ready, 1'b0);
      end
      periph.gnt = 0;
      begin
         int order[4] = '{2, 0, 3, 1};
         for (int k = 0; k < 4; k++) begin
            periph.r_valid = 1; periph.r_id = 2'(order[k]);
            periph.r_data = 32'hA0 + 32'(order[k]);
            cyc();
         end
      end
      periph.r_valid = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("bp_rsp_valid", s_rsp_valid, 1'b1);
         chk("bp_rsp_data", s_rsp_data, 32'hA0);
         chk("bp_no_req", s_req, 1'b0);
         chk("bp_ready", s_ready, 1'b0);
         chk("bp_id_err", s_id_err, 1'b0);
      end
      cmd_valid = 0; rsp_ready = 1;
      for (int i = 0; i < 10 && rsp_log.size() < 4; i++) cyc();
      rsp_ready = 0;
      chk("ooo_count", rsp_log.size(), 4);
      for (int i = 0; i < 4 && i < rsp_log.size(); i++)
         chk($sformatf("ooo_rsp%0d", i), rsp_log[i], 32'hA0 + 32'(i));
      cyc();
      chk("ooo_drained", s_out, 0);

      // ---------------- spurious response
      periph.r_valid = 1; periph.r_id = 2'd1; periph.r_data = 32'h55;
      cyc();
      periph.r_valid = 0;
      cyc();
      chk("spur_id_err", s_id_err, 1'b1);
      chk("spur_no_rsp", s_rsp_valid, 1'b0);
      repeat (3) cyc();
      chk("spur_sticky", s_id_err, 1'b1);

      // ---------------- reset in the middle of a transaction
      cmd_valid = 1; cmd_wen = 1; cmd_add = 32'h80; periph.gnt = 0;
      cyc();
      cmd_valid = 0;
      cyc();
      chk("mid_req_before_rst", s_req, 1'b1);
      do_reset();

`ifdef HWPE_CTRL_PERIPH_INITIATOR_TIMEOUT_EN
      // ---------------- timeout of an unanswered read
      cmd_valid = 1; cmd_wen = 1; cmd_add = 32'h40; periph.gnt = 1;
      cyc();
      cmd_valid = 0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         n++;
         if (s_rsp_valid) break;
      end
      // slot busy from the first sample on; done lands TO cycles later
      chk("to_latency", n, TO + 1);
      chk("to_err", s_rsp_err, 1'b1);
      chk("to_data", s_rsp_data, 32'hDEADBEEF);
      rsp_ready = 1;
      cyc();
      rsp_ready = 0;
      periph.r_valid = 1; periph.r_id = 2'd0; periph.r_data = 32'h77;
      cyc();
      periph.r_valid = 0;
      cyc();
      chk("to_late_id_err", s_id_err, 1'b1);
      do_reset();
`else
      n = 0;
`endif

      // ---------------- randomized traffic against the model
      granted.delete();
      for (int c = 0; c < 3000; c++) begin
         cmd_valid  = ($urandom_range(0, 3) != 0);
         cmd_add    = $urandom;
         cmd_wen    = 1'($urandom_range(0, 1));
         cmd_be     = 4'($urandom);
         cmd_data   = $urandom;
         periph.gnt = ($urandom_range(0, 2) != 0);
         rsp_ready  = ($urandom_range(0, 3) != 0);
         if (granted.size() > 0 && $urandom_range(0, 1) == 1) begin
            n = $urandom_range(0, granted.size() - 1);
            periph.r_valid = 1;
            periph.r_id    = 2'(granted[n]);
            periph.r_data  = $urandom;
            granted.delete(n);
         end else begin
            periph.r_valid = 0;
         end
         cyc();
         if (s_req && periph.gnt) granted.push_back(s_id);
      end
      cmd_valid = 0; periph.r_valid = 0; rsp_ready = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
